// File: rtl/bp_fe_queue_buffer.sv
// Replayable FE queue buffer. Entries are issued through a speculative read
// pointer and stay resident until the BE commits them, so issue can be replayed.
module bp_fe_queue_buffer #(
  parameter int els_p   = 8,
  parameter int width_p = 128,
  localparam int ptr_width_lp = $clog2(els_p) + 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [width_p-1:0]      fe_queue_i,
  input  logic                    fe_queue_v_i,
  output logic                    fe_queue_ready_and_o,
  output logic [width_p-1:0]      fe_queue_o,
  output logic                    fe_queue_v_o,
  input  logic                    fe_queue_yumi_i,
  input  logic                    deq_i,
  input  logic                    roll_i,
  input  logic                    clr_i,
  output logic [ptr_width_lp-1:0] count_o
);

  localparam logic [ptr_width_lp-1:0] els_lp = ptr_width_lp'(els_p);
  localparam logic [ptr_width_lp-1:0] one_lp = ptr_width_lp'(1);

  logic [width_p-1:0]      mem_q [els_p];
  logic [ptr_width_lp-1:0] wptr_q, rptr_q, cptr_q;
  logic [ptr_width_lp-1:0] wptr_d, rptr_d, cptr_d;
  logic [ptr_width_lp-1:0] occ;
  logic                    full, spec_empty, enq;

  // Wrap bit makes occ reach els_p when full instead of aliasing to zero.
  assign occ        = wptr_q - cptr_q;
  assign full       = (occ == els_lp);
  assign spec_empty = (rptr_q == wptr_q);
  assign enq        = fe_queue_v_i & ~full & ~clr_i;

  assign fe_queue_ready_and_o = ~full;
  assign fe_queue_v_o         = ~spec_empty;
  assign fe_queue_o           = mem_q[rptr_q[ptr_width_lp-2:0]];
  assign count_o              = occ;

  always_comb begin
    cptr_d = cptr_q + (deq_i ? one_lp : '0);
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    if (clr_i) begin
      rptr_d = cptr_d;
      wptr_d = cptr_d;
    end else if (roll_i) begin
      rptr_d = cptr_d;
      wptr_d = wptr_q + (enq ? one_lp : '0);
    end else begin
      rptr_d = rptr_q + (fe_queue_yumi_i ? one_lp : '0);
      wptr_d = wptr_q + (enq ? one_lp : '0);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
    end
  end

  // Storage is intentionally unreset; pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q[ptr_width_lp-2:0]] <= fe_queue_i;
  end

`ifndef SYNTHESIS
  a_yumi_v: assert property (@(posedge clk_i) disable iff (reset_i)
    fe_queue_yumi_i |-> fe_queue_v_o);
  a_deq_issued: assert property (@(posedge clk_i) disable iff (reset_i)
    deq_i |-> (cptr_q != rptr_q));
  a_count_range: assert property (@(posedge clk_i) disable iff (reset_i)
    count_o <= els_lp);
`endif

endmodule

// File: tb/tb_bp_fe_queue_buffer.sv
// Directed bench for bp_fe_queue_buffer with els_p=4.
module tb_bp_fe_queue_buffer;
  localparam int ELS = 4;
  localparam int W   = 16;
  localparam int PW  = $clog2(ELS) + 1;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [W-1:0]  fe_queue_i;
  logic          fe_queue_v_i;
  logic          fe_queue_ready_and_o;
  logic [W-1:0]  fe_queue_o;
  logic          fe_queue_v_o;
  logic          fe_queue_yumi_i;
  logic          deq_i;
  logic          roll_i;
  logic          clr_i;
  logic [PW-1:0] count_o;

  int checks = 0;
  int errors = 0;

  bp_fe_queue_buffer #(.els_p(ELS), .width_p(W)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .fe_queue_i(fe_queue_i), .fe_queue_v_i(fe_queue_v_i),
    .fe_queue_ready_and_o(fe_queue_ready_and_o),
    .fe_queue_o(fe_queue_o), .fe_queue_v_o(fe_queue_v_o),
    .fe_queue_yumi_i(fe_queue_yumi_i), .deq_i(deq_i),
    .roll_i(roll_i), .clr_i(clr_i), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic idle();
    fe_queue_v_i = 0; fe_queue_yumi_i = 0; deq_i = 0; roll_i = 0; clr_i = 0;
    fe_queue_i = '0;
  endtask

  task automatic do_reset();
    idle();
    reset_i = 1; #7; reset_i = 0; #0;
  endtask

  task automatic push(input logic [W-1:0] d);
    fe_queue_v_i = 1; fe_queue_i = d; tick(); idle();
  endtask

  task automatic test_reset();
    idle(); reset_i = 1; #12;
    checks++; if (fe_queue_v_o !== 1'b0) begin errors++; $display("FAIL reset_v got %b exp 0", fe_queue_v_o); end
    checks++; if (fe_queue_ready_and_o !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b exp 1", fe_queue_ready_and_o); end
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_o); end
    reset_i = 0; tick();
  endtask

  task automatic test_enqueue();
    do_reset();
    push(16'hA);
    checks++; if (fe_queue_v_o !== 1'b1) begin errors++; $display("FAIL enq_v got %b exp 1", fe_queue_v_o); end
    checks++; if (fe_queue_o !== 16'hA) begin errors++; $display("FAIL enq_head got %h exp 000a", fe_queue_o); end
    push(16'hB); push(16'hC);
    checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL enq_count got %0d exp 3", count_o); end
    checks++; if (fe_queue_ready_and_o !== 1'b1) begin errors++; $display("FAIL enq_rdy got %b exp 1", fe_queue_ready_and_o); end
    checks++; if (fe_queue_o !== 16'hA) begin errors++; $display("FAIL enq_head2 got %h exp 000a", fe_queue_o); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++) push(16'h10 + 16'(i));
    checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", count_o); end
    checks++; if (fe_queue_ready_and_o !== 1'b0) begin errors++; $display("FAIL full_rdy got %b exp 0", fe_queue_ready_and_o); end
    push(16'h99);
    checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL full_drop got %0d exp 4", count_o); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (fe_queue_o !== 16'h10 + 16'(i)) begin errors++; $display("FAIL full_issue%0d got %h exp %h", i, fe_queue_o, 16'h10 + 16'(i)); end
      fe_queue_yumi_i = 1; tick(); idle();
    end
    checks++; if (fe_queue_v_o !== 1'b0) begin errors++; $display("FAIL full_drained_v got %b exp 0", fe_queue_v_o); end
    checks++; if (fe_queue_ready_and_o !== 1'b0) begin errors++; $display("FAIL full_still_full got %b exp 0", fe_queue_ready_and_o); end
    deq_i = 1; #1;
    checks++; if (fe_queue_ready_and_o !== 1'b0) begin errors++; $display("FAIL full_deq_same_cycle got %b exp 0", fe_queue_ready_and_o); end
    tick(); idle();
    checks++; if (fe_queue_ready_and_o !== 1'b1) begin errors++; $display("FAIL full_deq_rdy got %b exp 1", fe_queue_ready_and_o); end
    checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL full_deq_count got %0d exp 3", count_o); end
  endtask

  task automatic test_roll();
    do_reset();
    for (int i = 0; i < 4; i++) push(16'h20 + 16'(i));
    fe_queue_yumi_i = 1; tick(); tick(); idle();
    checks++; if (fe_queue_o !== 16'h22) begin errors++; $display("FAIL roll_pre got %h exp 0022", fe_queue_o); end
    deq_i = 1; tick(); idle();
    roll_i = 1; tick(); idle();
    checks++; if (fe_queue_o !== 16'h21) begin errors++; $display("FAIL roll_head got %h exp 0021", fe_queue_o); end
    checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL roll_count got %0d exp 3", count_o); end
    for (int i = 1; i < 4; i++) begin
      checks++; if (fe_queue_o !== 16'h20 + 16'(i)) begin errors++; $display("FAIL roll_reissue%0d got %h exp %h", i, fe_queue_o, 16'h20 + 16'(i)); end
      fe_queue_yumi_i = 1; tick(); idle();
    end
    checks++; if (fe_queue_v_o !== 1'b0) begin errors++; $display("FAIL roll_end_v got %b exp 0", fe_queue_v_o); end
  endtask

  task automatic test_clr();
    do_reset();
    push(16'h30); push(16'h31); push(16'h32);
    fe_queue_yumi_i = 1; tick(); idle();
    clr_i = 1; deq_i = 1; fe_queue_v_i = 1; fe_queue_i = 16'hE; tick(); idle();
    checks++; if (fe_queue_v_o !== 1'b0) begin errors++; $display("FAIL clr_v got %b exp 0", fe_queue_v_o); end
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL clr_count got %0d exp 0", count_o); end
    checks++; if (fe_queue_ready_and_o !== 1'b1) begin errors++; $display("FAIL clr_rdy got %b exp 1", fe_queue_ready_and_o); end
    push(16'hF);
    checks++; if (fe_queue_o !== 16'hF) begin errors++; $display("FAIL clr_next got %h exp 000f", fe_queue_o); end
    checks++; if (count_o !== 3'd1) begin errors++; $display("FAIL clr_next_count got %0d exp 1", count_o); end
  endtask

  task automatic test_wrap();
    do_reset();
    push(16'h100);
    for (int k = 1; k < 10; k++) begin
      checks++; if (fe_queue_o !== 16'h100 + 16'(k - 1)) begin errors++; $display("FAIL wrap_out%0d got %h exp %h", k, fe_queue_o, 16'h100 + 16'(k - 1)); end
      checks++; if (fe_queue_ready_and_o !== 1'b1) begin errors++; $display("FAIL wrap_rdy%0d got %b exp 1", k, fe_queue_ready_and_o); end
      checks++; if (count_o !== ((k == 1) ? 3'd1 : 3'd2)) begin errors++; $display("FAIL wrap_count%0d got %0d exp %0d", k, count_o, (k == 1) ? 1 : 2); end
      fe_queue_v_i = 1; fe_queue_i = 16'h100 + 16'(k);
      fe_queue_yumi_i = 1; deq_i = (k > 1); tick(); idle();
    end
    checks++; if (fe_queue_o !== 16'h109) begin errors++; $display("FAIL wrap_last got %h exp 0109", fe_queue_o); end
    fe_queue_yumi_i = 1; deq_i = 1; tick(); idle();
    deq_i = 1; tick(); idle();
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL wrap_end_count got %0d exp 0", count_o); end
    checks++; if (fe_queue_v_o !== 1'b0) begin errors++; $display("FAIL wrap_end_v got %b exp 0", fe_queue_v_o); end
  endtask

  task automatic test_async_reset();
    do_reset();
    push(16'h40); push(16'h41); push(16'h42); push(16'h43);
    fe_queue_v_i = 1; fe_queue_i = 16'h44; #2;
    reset_i = 1; #1;
    checks++; if (fe_queue_v_o !== 1'b0) begin errors++; $display("FAIL arst_v got %b exp 0", fe_queue_v_o); end
    checks++; if (fe_queue_ready_and_o !== 1'b1) begin errors++; $display("FAIL arst_rdy got %b exp 1", fe_queue_ready_and_o); end
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL arst_count got %0d exp 0", count_o); end
    idle(); #3; reset_i = 0; tick();
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL arst_after got %0d exp 0", count_o); end
  endtask

  initial begin
    idle();
    test_reset();
    test_enqueue();
    test_full();
    test_roll();
    test_clr();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bp_fe_queue_buffer.md
Name: bp_fe_queue_buffer

Overview:
- Replayable FIFO directly downstream of the FE controller's fe_queue output; buffers fetch/exception packets for BE issue.
- Three pointers:
  - write: enqueue.
  - speculative read: issue.
  - committed: retire/free.
- Entries stay resident until committed, so the BE can roll issue back (replay) or clear all uncommitted state on redirect.
- fe_queue_ready_and_o drives the controller's fe_queue_ready_and_i.

Parameters:
- els_p, 8, entry count; power of two, >= 2.
- width_p, 128, bits per entry (fe_queue packet width).
- ptr_width_lp, $clog2(els_p)+1, pointer width (index plus wrap bit); localparam.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- fe_queue_i  in  width_p  packet from FE.
- fe_queue_v_i  in  1  packet valid.
- fe_queue_ready_and_o  out  1  buffer can accept this cycle.
- fe_queue_o  out  width_p  packet at speculative read pointer.
- fe_queue_v_o  out  1  unissued packet available.
- fe_queue_yumi_i  in  1  BE issues (consumes) head packet.
- deq_i  in  1  commit oldest issued packet; frees its slot.
- roll_i  in  1  rewind read pointer to commit point (replay).
- clr_i  in  1  discard all uncommitted and unissued packets.
- count_o  out  ptr_width_lp  occupied entries (write minus committed).

Behaviour:

Reset:
- Clock is clk_i only; reset_i is asynchronous and active-high.
- wptr_r, rptr_r and cptr_r all go to 0.
- Outputs after reset: fe_queue_v_o=0, fe_queue_ready_and_o=1, count_o=0.
- Storage is not reset; fe_queue_o is don't-care while fe_queue_v_o=0.
- Reset asserted mid-operation drops all contents immediately.

Derived signals:
- full = (wptr_r - cptr_r) == els_p.
- spec_empty = (rptr_r == wptr_r).
- fe_queue_ready_and_o = ~full. It depends on registered state only, with no combinational path from any input.
- fe_queue_v_o = ~spec_empty. fe_queue_o = mem[rptr_r index], read combinationally.

Handshakes:
- enq = fe_queue_v_i & fe_queue_ready_and_o & ~clr_i. On enq, write mem[wptr_r] and increment wptr.
- yumi: increment rptr. Legal only while fe_queue_v_o=1.
- deq_i: increment cptr. Legal only while cptr_r != rptr_r, i.e. an issued packet exists.
- A deq_i in the cycle a slot frees does not raise ready_and until the next cycle.

Next-state pointers (priority per cycle):
- cptr_n = cptr_r + deq_i. Commit is always honoured, including alongside roll_i or clr_i.
- clr_i (highest): rptr_n = wptr_n = cptr_n. Same-cycle enq, yumi and roll are ignored.
- else roll_i: rptr_n = cptr_n; wptr_n = wptr_r + enq. Same-cycle yumi is ignored.
- else: rptr_n = rptr_r + yumi; wptr_n = wptr_r + enq.

Arithmetic:
- All pointer arithmetic is modulo 2^ptr_width_lp.
- Storage index = pointer[ptr_width_lp-2:0].
- The wrap bit distinguishes full from empty.

Simultaneous events and boundaries:
- Enqueue and yumi in the same cycle are allowed, including when exactly one entry is unissued: the head advances and the new entry becomes visible next cycle.
- There is no bypass: a packet written in cycle N is first presented at N+1 (minimum latency 1).
- When full, fe_queue_v_i is ignored and no write occurs.
- A roll with no issued entries is a no-op.

count_o:
- count_o = wptr_r - cptr_r, registered, in the range 0..els_p.

Assertions (simulation only):
- yumi while ~fe_queue_v_o.
- deq_i while cptr_r == rptr_r.
- count_o > els_p.

Test Plan:
1. Reset, then enqueue A,B,C (els_p=4) -> v_o=1 at the cycle after A with fe_queue_o=A; count_o=3; ready_and=1.
2. Enqueue 4 packets with no deq -> count_o=4, ready_and=0; a 5th valid is dropped; yumi all 4 -> still full until deq_i; after deq_i, ready_and=1 next cycle.
3. Enqueue A..D, yumi A,B, deq_i A, roll_i -> next cycle fe_queue_o=B, count_o=3; re-issue B,C,D in order.
4. Enqueue A..C, yumi A, assert clr_i together with deq_i and fe_queue_v_i(E) -> next cycle v_o=0, count_o=0, E not stored.
5. Wrap: stream 10 packets through with yumi+deq every cycle and concurrent enqueue -> outputs in order; pointers wrap; full never asserts falsely.
6. Assert reset_i asynchronously mid-stream (between clock edges) -> v_o=0, ready_and=1, count_o=0 immediately, before the next edge.
